// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture peripheral with Avalon-MM register access
module pwm_capture #(
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    input  logic        pwm_i
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    logic                 s1, s2, s3;
    logic                 rise;
    logic [CNT_WIDTH-1:0] cnt, hcnt;
    logic                 armed;
    logic [CNT_WIDTH-1:0] period_reg, high_reg, shadow;
    logic                 valid, timeout, new_sample;
    logic                 enable, irq_en;
    logic                 ctrl_wr, clear, rd_period;
    logic                 capture, tmo_hit;
    logic                 unused_wdata;

    assign rise      = s2 & ~s3;
    assign ctrl_wr   = write && (address == 2'd3);
    assign clear     = ctrl_wr && writedata[1];
    assign rd_period = read && (address == 2'd0);
    assign capture   = enable && armed && rise;
    // A rise in the timeout cycle counts as a capture, so timeout is suppressed.
    assign tmo_hit   = enable && !rise && (cnt == TIMEOUT_VAL);
    assign irq       = new_sample & irq_en;
    assign unused_wdata = ^writedata[31:3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            hcnt  <= '0;
            armed <= 1'b0;
        end else if (clear || !enable) begin
            cnt   <= '0;
            hcnt  <= '0;
            armed <= 1'b0;
        end else if (rise) begin
            cnt   <= CNT_WIDTH'(1);
            hcnt  <= CNT_WIDTH'(1);
            armed <= 1'b1;
        end else begin
            if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            if (s2 && hcnt != CNT_MAX) begin
                hcnt <= hcnt + 1'b1;
            end
            if (tmo_hit) begin
                armed <= 1'b0;
            end
        end
    end

    // Capture sets new_sample after the read clears it, so a coincident capture wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_reg <= '0;
            high_reg   <= '0;
            shadow     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            new_sample <= 1'b0;
        end else if (clear) begin
            period_reg <= '0;
            high_reg   <= '0;
            shadow     <= '0;
            valid      <= 1'b0;
            timeout    <= 1'b0;
            new_sample <= 1'b0;
        end else begin
            if (rd_period) begin
                shadow     <= high_reg;
                new_sample <= 1'b0;
            end
            if (capture) begin
                period_reg <= cnt;
                high_reg   <= hcnt;
                valid      <= 1'b1;
                timeout    <= 1'b0;
                new_sample <= 1'b1;
            end else if (tmo_hit) begin
                period_reg <= '0;
                high_reg   <= '0;
                valid      <= 1'b0;
                timeout    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
        end else if (ctrl_wr) begin
            enable <= writedata[0];
            irq_en <= writedata[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else if (read) begin
            case (address)
                2'd0:    readdata <= 32'(period_reg);
                2'd1:    readdata <= 32'(shadow);
                2'd2:    readdata <= {28'b0, new_sample, s2, timeout, valid};
                default: readdata <= {29'b0, irq_en, 1'b0, enable};
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        pwm_i;

    int checks   = 0;
    int failures = 0;
    logic [31:0] d;

    pwm_capture #(.CNT_WIDTH(32), .TIMEOUT_CYCLES(1000)) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .pwm_i     (pwm_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] data);
        address = a;
        read    = 1'b1;
        @(negedge clk);
        read    = 1'b0;
        data    = readdata;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] data);
        address   = a;
        writedata = data;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic pwm_cycles(input int period, input int high, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_i = 1'b1;
            repeat (high) @(negedge clk);
            pwm_i = 1'b0;
            repeat (period - high) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0;
        writedata = 32'd0; pwm_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 32'd0);
        check("rst_irq", irq, 32'd0);
        reset = 1'b0;
        bus_read(2'd3, d); check("rst_ctrl", d, 32'd0);

        // 100/25 measurement
        bus_write(2'd3, 32'h1);
        pwm_cycles(100, 25, 4);
        bus_read(2'd2, d); check("m1_status_pre", d, 32'h9);
        bus_read(2'd0, d); check("m1_period", d, 32'd100);
        bus_read(2'd1, d); check("m1_high", d, 32'd25);
        bus_read(2'd2, d); check("m1_status_post", d, 32'h1);

        // single rise then held high -> timeout
        bus_write(2'd3, 32'h3);
        pwm_i = 1'b1;
        repeat (1010) @(negedge clk);
        bus_read(2'd2, d); check("to_status", d, 32'h6);
        bus_read(2'd0, d); check("to_period", d, 32'd0);
        bus_read(2'd1, d); check("to_high", d, 32'd0);
        pwm_i = 1'b0;
        repeat (20) @(negedge clk);
        pwm_cycles(50, 10, 1);
        bus_read(2'd2, d); check("to_rearm_status", d, 32'h2);
        pwm_cycles(50, 10, 2);
        bus_read(2'd2, d); check("to_resume_status", d, 32'h9);
        bus_read(2'd0, d); check("to_resume_period", d, 32'd50);
        bus_read(2'd1, d); check("to_resume_high", d, 32'd10);

        // interrupt timing with 40/20
        bus_write(2'd3, 32'h7);
        check("irq_after_clear", irq, 32'd0);
        pwm_i = 1'b1; repeat (20) @(negedge clk);
        pwm_i = 1'b0; repeat (20) @(negedge clk);
        pwm_i = 1'b1;
        @(negedge clk); check("irq_rise_plus1", irq, 32'd0);
        @(negedge clk); check("irq_rise_plus2", irq, 32'd0);
        @(negedge clk); check("irq_rise_plus3", irq, 32'd1);
        repeat (17) @(negedge clk);
        pwm_i = 1'b0; repeat (19) @(negedge clk);
        bus_read(2'd0, d);
        check("irq_read_period", d, 32'd40);
        check("irq_dropped", irq, 32'd0);
        pwm_i = 1'b1;
        repeat (3) @(negedge clk);
        check("irq_reassert", irq, 32'd1);
        pwm_i = 1'b0;
        repeat (5) @(negedge clk);

        // addr0 read in the exact capture cycle
        bus_write(2'd3, 32'h3);
        pwm_cycles(60, 15, 1);
        pwm_cycles(80, 30, 1);
        pwm_i = 1'b1;
        repeat (2) @(negedge clk);
        bus_read(2'd0, d); check("coin_period_old", d, 32'd60);
        bus_read(2'd2, d); check("coin_status", d, 32'hD);
        bus_read(2'd1, d); check("coin_high_old", d, 32'd15);
        bus_read(2'd0, d); check("coin_period_new", d, 32'd80);
        bus_read(2'd1, d); check("coin_high_new", d, 32'd30);
        pwm_i = 1'b0;
        repeat (5) @(negedge clk);

        // clear mid-measurement, then disable
        pwm_cycles(30, 10, 3);
        bus_write(2'd3, 32'h3);
        bus_read(2'd0, d); check("clr_period", d, 32'd0);
        bus_read(2'd1, d); check("clr_high", d, 32'd0);
        bus_read(2'd2, d); check("clr_status", d, 32'h0);
        pwm_i = 1'b1; repeat (10) @(negedge clk);
        pwm_i = 1'b0; repeat (10) @(negedge clk);
        bus_read(2'd2, d); check("clr_first_rise_status", d, 32'h0);
        bus_read(2'd0, d); check("clr_first_rise_period", d, 32'd0);
        bus_write(2'd3, 32'h0);
        repeat (2000) @(negedge clk);
        bus_read(2'd2, d); check("dis_status", d, 32'h0);
        bus_read(2'd3, d); check("dis_ctrl", d, 32'h0);

        // reset during a high phase
        bus_write(2'd3, 32'h5);
        pwm_cycles(40, 10, 3);
        bus_read(2'd3, d); check("pre_rst_ctrl", d, 32'h5);
        check("pre_rst_irq", irq, 32'd1);
        pwm_i = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_readdata", readdata, 32'd0);
        check("mid_rst_irq", irq, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(2'd3, d); check("post_rst_ctrl", d, 32'h0);
        repeat (3) @(negedge clk);
        bus_read(2'd2, d); check("post_rst_status", d, 32'h4);
        bus_write(2'd3, 32'h1);
        pwm_i = 1'b0;
        repeat (5) @(negedge clk);
        pwm_cycles(40, 10, 2);
        bus_read(2'd0, d); check("post_rst_period", d, 32'd40);
        bus_read(2'd1, d); check("post_rst_high", d, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Avalon-MM slave peripheral for the Nios system. It measures an incoming PWM waveform, and is the receive-side counterpart of the system's PWM output.
- Synchronises the external pwm_i pin and counts clock cycles between rising edges (period) and while high (high time).
- Exposes period and high time to software as coherent register snapshots, with status flags, timeout detection and an optional interrupt.

Parameters:
- CNT_WIDTH, 32, width of the period/high counters and result registers (must be ≤32).
- TIMEOUT_CYCLES, 50000000, cycles without a rising edge before a timeout is declared (1 s at 50 MHz); must be < 2^CNT_WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select: 0 period, 1 high snapshot, 2 status, 3 control.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- writedata  in  32  write data; only address 3 is writable.
- readdata  out  32  read data, registered, read latency 1.
- irq  out  1  level interrupt, equal to new_sample AND irq_en.
- pwm_i  in  1  asynchronous external PWM input.

Behaviour:
- Reset values: readdata=0, irq=0; all counters, result registers, shadow and flags 0; control register 0 (enable=0, irq_en=0); armed=0.
- Input path:
  - Sync chain s1 → s2, plus delay register s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - A pin edge produces rise/fall 3 clk later.
- Counting, while enable=1:
  - cnt: on rise, cnt <= 1. Otherwise it increments, saturating at all-ones.
  - hcnt: on rise, hcnt <= 1. Otherwise it increments while s2=1 and holds while s2=0.
- Capture, on rise when armed=1:
  - period_reg <= cnt; high_reg <= hcnt.
  - valid <= 1; timeout <= 0; new_sample <= 1.
  - Result: a signal with period P clocks and high time H clocks yields period_reg=P, high_reg=H.
- Arming: the first rise after reset, enable, clear or timeout only sets armed=1; no capture occurs.
- Timeout: when cnt == TIMEOUT_CYCLES and no rise occurs that cycle:
  - period_reg <= 0, high_reg <= 0.
  - valid <= 0, timeout <= 1, armed <= 0.
  - The constant level is reported via the status level bit.
  - The next rise re-arms measurement.
- Enable=0: cnt, hcnt and armed are held at 0 and no capture or timeout occurs. Result registers and flags keep their values.
- Register reads (readdata valid the cycle after read):
  - addr 0: period_reg, zero-extended. The same cycle copies high_reg into the shadow and clears new_sample.
  - addr 1: the shadow value. This guarantees the period/high pair is coherent if software reads addr 0 then addr 1.
  - addr 2: {28'b0, new_sample, level=s2, timeout, valid} (bit3..bit0).
  - addr 3: {29'b0, irq_en, 1'b0, enable}.
  - When read is not asserted, readdata holds its last value.
- Register writes (addr 3 only; writes to addresses 0–2 are ignored):
  - bit0 = enable.
  - bit1 = clear, a self-clearing pulse. It zeroes period_reg, high_reg, shadow, valid, timeout, new_sample, cnt, hcnt and armed.
  - bit2 = irq_en.
- Simultaneous events:
  - Capture and addr-0 read in the same cycle: the read returns the old period and the shadow takes the old high value; new_sample ends at 1 (set wins).
  - Capture and clear in the same cycle: clear wins.
  - Rise on the cycle cnt == TIMEOUT_CYCLES: capture wins and no timeout is flagged.
- Reset asserted mid-measurement: all state returns to the reset values immediately; measurement restarts disarmed.
- Boundary cases:
  - 0% or 100% duty input: no rises occur, so timeout is flagged and the level bit gives 0 or 1.
  - Pulses shorter than 1 clk may be missed; this is not required to be handled.

Test Plan:
- Enable (write addr3=0x1), drive PWM with period 100 clk and high 25 clk for 4 periods, read addr0 then addr1 → 100 and 25. Status reads 0b0001 after the addr0 read, and reads 0b1001 or 0b1101 before it.
- Only one rise after enable, then the pin is held high for TIMEOUT_CYCLES+10 (use TIMEOUT_CYCLES=1000) → status timeout=1, valid=0, level=1, period=0, high=0. Resuming a 50/10 PWM → valid after the second rise with period 50 and high 10.
- irq_en=1 with a 40/20 PWM → irq rises 3 clk after the second pin rise edge; an addr0 read drops irq the following cycle; irq reasserts on the next capture.
- Addr0 read issued in the exact capture cycle → returns the previous period and the addr1 read returns the matching previous high; new_sample remains 1.
- Write clear (0x3) mid-measurement → all results are 0 and the first new rise produces no capture. Write enable=0 → counters stay 0 and no timeout occurs after 2×TIMEOUT_CYCLES.
- Assert reset during a high phase → readdata=0, irq=0, control=0. After re-enabling, the first full period is measured correctly.
